// File: rtl/inter_clock_pkg.sv
// -----------------------------------------------------------------------------
// inter_clock_pkg
// Shared types and helpers for the inter-clock sample bridge.
//   state_e   : capture FSM states (HOLDOFF, ARMED, CAPTURE)
//   wd_width  : width of the stale watchdog counter, clog2(timeout + 1)
// -----------------------------------------------------------------------------
package inter_clock_pkg;

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // The counter must be able to hold the value `timeout` itself, because the
  // stale condition is defined as count == timeout.
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings a slow clock, treated as plain data, into the local clock domain and
// reports its transitions.
//   Parameters : SYNC_STAGES (2..4) synchroniser depth
//                RISE        1 = edge_o marks rising transitions, 0 = falling
//   clock      in  local clock, rising edge
//   reset_n    in  asynchronous active-low reset
//   din_i      in  asynchronous slow clock level
//   level_o    out synchronised level (last synchroniser stage)
//   edge_o     out one-cycle pulse on the selected transition
//   toggle_o   out one-cycle pulse on any transition of level_o
// -----------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter bit RISE        = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din_i,
  output logic level_o,
  output logic edge_o,
  output logic toggle_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;   // level one cycle earlier, for edge detection

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o  = sync_q[SYNC_STAGES-1];
  assign toggle_o = level_o ^ prev_q;

  generate
    if (RISE) begin : g_rise
      assign edge_o = level_o & ~prev_q;
    end else begin : g_fall
      assign edge_o = ~level_o & prev_q;
    end
  endgenerate

endmodule

// File: rtl/inter_clock_bridge.sv
// -----------------------------------------------------------------------------
// inter_clock_bridge
// Captures CHANNELS samples produced under a slow clock (clock_low, sampled as
// data) into the fast clock domain on the selected edge of the synchronised
// slow clock, with a one-cycle valid strobe and a stale-source watchdog.
//   Parameters : DATA_WIDTH, CHANNELS, SYNC_STAGES (2..4),
//                CAPTURE_RISE (1 = rising, 0 = falling), TIMEOUT (>= 2)
//   clock      in  fast system clock
//   reset_n    in  asynchronous active-low reset
//   clock_low  in  slow source clock, sampled as data
//   data_in    in  packed channels, channel k = [k*DATA_WIDTH +: DATA_WIDTH]
//   data_out   out captured samples, same packing
//   valid      out one-cycle pulse when data_out is updated
//   stale      out no capture for TIMEOUT cycles (and since reset)
// Build option: INTER_CLOCK_STALE_MUTE_EN -- when defined, data_out reads zero
// while stale is high; the stored samples are kept.
// -----------------------------------------------------------------------------
module inter_clock_bridge
  import inter_clock_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CHANNELS     = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int CAPTURE_RISE = 1,
  parameter int TIMEOUT      = 1024
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           clock_low,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           valid,
  output logic                           stale
);

  localparam int            WD_W   = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  // Level of the synchronised clock just before a capturing edge.
  localparam logic          PRE_LEVEL = (CAPTURE_RISE != 0) ? 1'b0 : 1'b1;

  logic level, edge_det, toggle;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RISE        (CAPTURE_RISE != 0)
  ) u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .din_i    (clock_low),
    .level_o  (level),
    .edge_o   (edge_det),
    .toggle_o (toggle)
  );

  // HOLDOFF leaves only on an actual transition back to the pre-edge level.
  // After a capture the level sits at the post-edge value, so this is the
  // return to the pre-edge level; straight out of reset it means the
  // synchroniser's zero reset value never counts as a real opposite phase,
  // so an edge already present at reset release is not captured.
  logic rearm;
  assign rearm = toggle & (level == PRE_LEVEL);

  state_e          state_q;
  logic            valid_q;
  logic            stale_q;
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;

  // Saturating watchdog increment.
  assign wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

  // stale is a set/clear flag: it leaves reset high, is cleared by a capture,
  // and is set again once the watchdog reaches TIMEOUT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLDOFF;
      valid_q <= 1'b0;
      stale_q <= 1'b1;
      wd_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      wd_q    <= wd_d;
      if (wd_d == WD_MAX) begin
        stale_q <= 1'b1;
      end
      case (state_q)
        HOLDOFF: begin
          if (rearm) state_q <= ARMED;
        end
        ARMED: begin
          if (edge_det) state_q <= CAPTURE;
        end
        CAPTURE: begin
          valid_q <= 1'b1;
          wd_q    <= '0;
          stale_q <= 1'b0;
          state_q <= HOLDOFF;
        end
        default: state_q <= HOLDOFF;
      endcase
    end
  end

  assign valid = valid_q;
  assign stale = stale_q;

  // Per-channel capture registers, loaded together in CAPTURE so data_out
  // changes in the same cycle valid pulses.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [DATA_WIDTH-1:0] ch_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ch_q <= '0;
        end else if (state_q == CAPTURE) begin
          ch_q <= data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

`ifdef INTER_CLOCK_STALE_MUTE_EN
      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = stale_q ? '0 : ch_q;
`else
      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = ch_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_inter_clock_bridge.sv
module tb_inter_clock_bridge;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int W  = DW * CH;
  localparam int TO = 16;
`ifdef INTER_CLOCK_STALE_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic         clock_low;
  logic [W-1:0] data_in;

  logic [W-1:0] dout_a, dout_b, dout_c;
  logic         valid_a, valid_b, valid_c;
  logic         stale_a, stale_b, stale_c;

  always #5 clock = ~clock;

  // a: 2 stages, rising; b: 2 stages, falling; c: 4 stages, rising
  inter_clock_bridge #(.DATA_WIDTH(DW), .CHANNELS(CH), .SYNC_STAGES(2),
                       .CAPTURE_RISE(1), .TIMEOUT(TO)) dut_a (
    .clock(clock), .reset_n(reset_n), .clock_low(clock_low), .data_in(data_in),
    .data_out(dout_a), .valid(valid_a), .stale(stale_a));

  inter_clock_bridge #(.DATA_WIDTH(DW), .CHANNELS(CH), .SYNC_STAGES(2),
                       .CAPTURE_RISE(0), .TIMEOUT(TO)) dut_b (
    .clock(clock), .reset_n(reset_n), .clock_low(clock_low), .data_in(data_in),
    .data_out(dout_b), .valid(valid_b), .stale(stale_b));

  inter_clock_bridge #(.DATA_WIDTH(DW), .CHANNELS(CH), .SYNC_STAGES(4),
                       .CAPTURE_RISE(1), .TIMEOUT(TO)) dut_c (
    .clock(clock), .reset_n(reset_n), .clock_low(clock_low), .data_in(data_in),
    .data_out(dout_c), .valid(valid_c), .stale(stale_c));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: per instance, a selected transition of clock_low is
  // accepted only if an opposite transition was seen since the last accepted
  // one (or since reset); it appears on valid SYNC_STAGES+2 edges after the
  // change was driven, carrying the data present at the transition.
  int           s_of     [3];
  bit           rise_of  [3];
  bit           opp_seen [3];
  bit           pend     [3];
  int           pend_t   [3];
  logic [W-1:0] pend_d   [3];
  logic [W-1:0] held     [3];
  bit           have_cap [3];
  int           last_cap [3];
  int           vcount   [3];
  logic         prev_cl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      opp_seen[i] = 1'b0;
      pend[i]     = 1'b0;
      held[i]     = '0;
      have_cap[i] = 1'b0;
      last_cap[i] = 0;
    end
    prev_cl = 1'b0;
  endtask

  // One fast cycle: update the model from the sampled inputs, then compare
  // every instance's outputs 1 time unit after the edge.
  task automatic tick();
    logic         cur;
    logic         exp_v, exp_s;
    logic [W-1:0] exp_d;
    logic         obs_v, obs_s;
    logic [W-1:0] obs_d;
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      model_reset();
    end else begin
      cur = clock_low;
      if (cur != prev_cl) begin
        for (int i = 0; i < 3; i++) begin
          if (cur == rise_of[i]) begin
            if (opp_seen[i]) begin
              pend[i]     = 1'b1;
              pend_t[i]   = cyc + s_of[i] + 1;
              pend_d[i]   = data_in;
              opp_seen[i] = 1'b0;
            end
          end else begin
            opp_seen[i] = 1'b1;
          end
        end
      end
      prev_cl = cur;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_v = pend[i] && (pend_t[i] == cyc);
      if (exp_v) begin
        pend[i]     = 1'b0;
        held[i]     = pend_d[i];
        have_cap[i] = 1'b1;
        last_cap[i] = cyc;
      end
      exp_s = !have_cap[i] || ((cyc - last_cap[i]) >= TO);
      exp_d = (MUTE && exp_s) ? '0 : held[i];
      case (i)
        0:       begin obs_v = valid_a; obs_s = stale_a; obs_d = dout_a; end
        1:       begin obs_v = valid_b; obs_s = stale_b; obs_d = dout_b; end
        default: begin obs_v = valid_c; obs_s = stale_c; obs_d = dout_c; end
      endcase
      if (obs_v === 1'b1) vcount[i]++;
      chk($sformatf("dut%0d_valid@%0d", i, cyc), {31'd0, obs_v}, {31'd0, exp_v});
      chk($sformatf("dut%0d_stale@%0d", i, cyc), {31'd0, obs_s}, {31'd0, exp_s});
      chk($sformatf("dut%0d_data@%0d", i, cyc), obs_d, exp_d);
    end
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int n;
    int vbefore;
    logic [W-1:0] snap;
    s_of[0] = 2; s_of[1] = 2; s_of[2] = 4;
    rise_of[0] = 1'b1; rise_of[1] = 1'b0; rise_of[2] = 1'b1;
    for (int i = 0; i < 3; i++) vcount[i] = 0;
    model_reset();
    reset_n   = 1'b0;
    clock_low = 1'b0;
    data_in   = 32'h1234_ABCD;

    // Reset values
    hold(3);
    reset_n = 1'b1;

    // First capture comes on the second rising edge after reset
    hold(4);
    clock_low = 1'b1;
    hold(8);
    clock_low = 1'b0;
    hold(8);
    clock_low = 1'b1;
    n = 0;
    do begin tick(); n++; end while (valid_a !== 1'b1 && n < 20);
    chk("lat_s2", n, 4);
    chk("first_data", dout_a, 32'h1234_ABCD);
    chk("first_stale_drop", {31'd0, stale_a}, 32'd0);
    hold(8 - n);

    // Falling-edge capture with data changing on each falling edge
    vbefore = vcount[1];
    for (int k = 0; k < 4; k++) begin
      clock_low = 1'b0;
      data_in   = data_in + 32'h0001_0001;
      hold(8);
      clock_low = 1'b1;
      hold(8);
    end
    chk("fall_one_per_period", vcount[1] - vbefore, 4);
    chk("fall_last_data", dout_b, 32'h1238_ABD1);

    // Stop clock_low: stale exactly TIMEOUT cycles after the last valid
    clock_low = 1'b0;
    hold(8);
    data_in   = 32'h0BAD_BEEF;
    clock_low = 1'b1;
    n = 0;
    do begin tick(); n++; end while (valid_a !== 1'b1 && n < 20);
    n = 0;
    do begin tick(); n++; end while (stale_a !== 1'b1 && n < 40);
    chk("stale_after_valid", n, TO);
    chk("stale_data", dout_a, MUTE ? 32'h0 : 32'h0BAD_BEEF);
    hold(5);

    // Restart: next valid clears stale
    clock_low = 1'b0;
    hold(8);
    data_in   = 32'h7777_1111;
    clock_low = 1'b1;
    n = 0;
    do begin tick(); n++; end while (valid_a !== 1'b1 && n < 20);
    chk("restart_stale_clear", {31'd0, stale_a}, 32'd0);
    chk("restart_data", dout_a, 32'h7777_1111);
    hold(8 - n);

    // Asynchronous reset while a capture is pending
    clock_low = 1'b0;
    hold(8);
    data_in   = 32'hCAFE_F00D;
    clock_low = 1'b1;
    tick();
    for (int g = 0; g < 10 && cyc < pend_t[0] - 1; g++) tick();
    reset_n   = 1'b0;
    clock_low = 1'b0;
    #2;
    chk("rst_data_a", dout_a, 32'h0);
    chk("rst_valid_a", {31'd0, valid_a}, 32'd0);
    chk("rst_stale_a", {31'd0, stale_a}, 32'd1);
    chk("rst_data_b", dout_b, 32'h0);
    chk("rst_stale_c", {31'd0, stale_c}, 32'd1);
    hold(3);
    reset_n = 1'b1;

    // One-cycle high glitch during the post-reset hold-off
    hold(10);
    snap    = dout_a;
    vbefore = vcount[0];
    clock_low = 1'b1;
    tick();
    clock_low = 1'b0;
    hold(12);
    chk("glitch_no_valid", vcount[0] - vbefore, 0);
    chk("glitch_data_held", dout_a, snap);

    // Latency with four synchroniser stages
    data_in   = 32'h5A5A_0F0F;
    clock_low = 1'b1;
    n = 0;
    do begin tick(); n++; end while (valid_c !== 1'b1 && n < 20);
    chk("lat_s4", n, 6);
    chk("s4_data", dout_c, 32'h5A5A_0F0F);
    hold(4);

    // Randomised legal half-periods and data
    for (int k = 0; k < 24; k++) begin
      clock_low = ~clock_low;
      data_in   = $urandom;
      hold($urandom_range(12, 6));
    end
    hold(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
